// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    localparam logic [15:0] NOP_INSTR        = 16'h0800;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [15:0] PC_INC           = 16'd2;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load wins over increment; increment wraps modulo 2^PC_W.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + PC_W'(PC_INC);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, one-entry output buffer.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_cnt / squash_cnt outputs.
// Downstream handshake: instr is transferred on a rising edge where instr_valid && instr_ready;
// instr/instr_pc stay stable while instr_valid is high and instr_ready is low.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic [PC_W-1:0]    pc_plus2,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               err,
    output logic [1:0]         state_dbg
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        squash_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic            squash_q, squash_d;
    logic            req_due_q, req_due_d;
    logic            instr_valid_d, err_d;
    logic            pc_load, pc_inc, capture, hold_req;
    logic            redirect_act, handshake, rvalid_fresh;
    logic [PC_W-1:0] pc;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pc_load),
        .load_pc (redirect_pc),
        .inc     (pc_inc),
        .pc      (pc)
    );

    assign redirect_act = redirect_valid && (state_q != HALTED);
    assign handshake    = (state_q == HOLD) && instr_valid && instr_ready;
    // A response seen in the cycle a request is still being issued is stale.
    assign rvalid_fresh = imem_rvalid && !req_due_q;

    always_comb begin
        state_d       = state_q;
        squash_d      = squash_q;
        req_due_d     = 1'b0;
        instr_valid_d = instr_valid;
        err_d         = err;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;
        capture       = 1'b0;
        hold_req      = 1'b0;

        case (state_q)
            IDLE: begin
                state_d   = FETCH;
                req_due_d = 1'b1;
            end
            FETCH: begin
                if (rvalid_fresh) begin
                    if (squash_q) begin
                        squash_d  = 1'b0;
                        req_due_d = 1'b1;
                    end else begin
                        capture       = 1'b1;
                        pc_inc        = 1'b1;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end
            end
            HOLD: begin
                if (handshake) begin
                    instr_valid_d = 1'b0;
                    if (halt) begin
                        state_d = HALTED;
                    end else begin
                        hold_req = 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            default: begin
            end
        endcase

        // Redirect overrides everything computed above, including a same-cycle halt.
        if (redirect_act) begin
            capture       = 1'b0;
            pc_inc        = 1'b0;
            hold_req      = 1'b0;
            instr_valid_d = 1'b0;
            req_due_d     = 1'b0;
            if (redirect_pc[0]) begin
                err_d    = 1'b1;
                squash_d = 1'b0;
                state_d  = HALTED;
            end else begin
                pc_load = 1'b1;
                case (state_q)
                    IDLE: state_d = IDLE;
                    FETCH: begin
                        state_d = FETCH;
                        if (rvalid_fresh) begin
                            squash_d  = 1'b0;
                            req_due_d = 1'b1;
                        end else begin
                            squash_d = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            squash_q    <= 1'b0;
            req_due_q   <= 1'b0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
            instr       <= INSTR_W'(NOP_INSTR);
            instr_pc    <= '0;
        end else begin
            state_q     <= state_d;
            squash_q    <= squash_d;
            req_due_q   <= req_due_d;
            instr_valid <= instr_valid_d;
            err         <= err_d;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

    assign imem_req  = ((state_q == FETCH) && req_due_q) || hold_req;
    assign imem_addr = imem_req ? pc : '0;
    assign pc_plus2  = instr_pc + PC_W'(PC_INC);
    assign state_dbg = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc, squash_inc;

    assign fetch_inc  = handshake && !redirect_act;
    assign squash_inc = (state_q == FETCH) && imem_rvalid && !capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt  <= 16'd0;
            squash_cnt <= 16'd0;
        end else begin
            if (fetch_inc && (fetch_cnt != 16'hFFFF)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (squash_inc && (squash_cnt != 16'hFFFF)) begin
                squash_cnt <= squash_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder, directed scenarios, random redirects/stalls.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr, instr_pc, pc_plus2;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        err;
    logic [1:0]  state_dbg;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt, squash_cnt;
`endif

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus2       (pc_plus2),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .err            (err),
        .state_dbg      (state_dbg)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .squash_cnt     (squash_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- shared state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [15:0] mem [0:32767];
    logic [15:0] exp_q[$];
    bit          m_halted = 1'b0;
    bit          m_err = 1'b0;
    int          m_accepts = 0;
    int          lat_cfg = 1;
    bit          lat_rand = 1'b0;
    bit          spurious = 1'b0;
    bit          tput_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] mem_at(input logic [15:0] a);
        return mem[a[15:1]];
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        bit          busy = 1'b0;
        int          left = 0;
        logic [15:0] raddr = 16'h0000;
        forever begin
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            if (busy) begin
                if (left <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_at(raddr);
                    busy        = 1'b0;
                end else begin
                    left--;
                end
            end
            if (spurious && !imem_rvalid) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 16'($urandom);
            end
            @(negedge clk);
            if (imem_req) begin
                chk("single_outstanding", {31'd0, busy}, 32'd0);
                busy  = 1'b1;
                left  = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
                raddr = imem_addr;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          acc, prev_hold;
        logic [15:0] prev_instr, prev_pc, e, nxt;
        int          cyc, last_acc;
        prev_hold = 1'b0; prev_instr = '0; prev_pc = '0; cyc = 0; last_acc = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
                chk("rst_imem_addr", {16'd0, imem_addr}, 32'd0);
                chk("rst_instr", {16'd0, instr}, 32'h0800);
                chk("rst_instr_pc", {16'd0, instr_pc}, 32'd0);
                chk("rst_pc_plus2", {16'd0, pc_plus2}, 32'd2);
                chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
                chk("rst_err", {31'd0, err}, 32'd0);
                m_halted = 1'b0; m_err = 1'b0; m_accepts = 0;
                exp_q.delete();
                exp_q.push_back(RESET_PC);
                prev_hold = 1'b0; last_acc = -1;
            end else begin
                chk("err", {31'd0, err}, {31'd0, m_err});
                if (m_halted) begin
                    chk("halted_no_req", {31'd0, imem_req}, 32'd0);
                    chk("halted_no_valid", {31'd0, instr_valid}, 32'd0);
                end else begin
                    acc = instr_valid && instr_ready && !redirect_valid;
                    if (prev_hold) begin
                        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
                        chk("hold_instr", {16'd0, instr}, {16'd0, prev_instr});
                        chk("hold_instr_pc", {16'd0, instr_pc}, {16'd0, prev_pc});
                    end
                    if (instr_valid && !acc && !redirect_valid)
                        chk("hold_no_req", {31'd0, imem_req}, 32'd0);
                    if (acc) begin
                        if (exp_q.size() == 0) begin
                            chk("accept_expected", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            m_accepts++;
                            chk("instr_pc", {16'd0, instr_pc}, {16'd0, e});
                            chk("instr", {16'd0, instr}, {16'd0, mem_at(e)});
                            chk("pc_plus2", {16'd0, pc_plus2}, {16'd0, e + 16'd2});
                            if (tput_chk && last_acc >= 0)
                                chk("throughput_gap", last_acc[31:0] + 32'd2, cyc[31:0]);
                            last_acc = tput_chk ? cyc : -1;
                            if (halt) begin
                                m_halted = 1'b1;
                            end else begin
                                nxt = e + 16'd2;
                                exp_q.push_back(nxt);
                                chk("next_req", {31'd0, imem_req}, 32'd1);
                                chk("next_req_addr", {16'd0, imem_addr}, {16'd0, nxt});
                            end
                        end
                    end
                    if (redirect_valid) begin
                        exp_q.delete();
                        if (redirect_pc[0]) begin
                            m_err = 1'b1;
                            m_halted = 1'b1;
                        end else begin
                            exp_q.push_back(redirect_pc);
                        end
                    end
                    prev_hold = instr_valid && !acc && !redirect_valid;
                    prev_instr = instr;
                    prev_pc = instr_pc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; halt = 1'b0; spurious = 1'b0;
        tick(4);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = imem_req;
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic redirect_to(input logic [15:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        tick(1);
        redirect_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h4001;

        // basic flow and throughput with 1-cycle memory
        lat_cfg = 1; instr_ready = 1'b1;
        tick(2);
        do_reset();
        wait_req("first_req");
        chk("first_req_addr", {16'd0, imem_addr}, 32'd0);
        tput_chk = 1'b1;
        tick(14);
        tput_chk = 1'b0;

        // downstream stall
        instr_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = instr_valid;
        end
        chk("stall_valid_seen", {31'd0, ok}, 32'd1);
        tick(5);
        instr_ready = 1'b1;
        tick(8);

        // squash of an in-flight request
        do_reset();
        lat_cfg = 3;
        wait_req("squash_req0");
        tick(1);
        redirect_to(16'h0040);
        wait_req("squash_req1");
        chk("squash_next_addr", {16'd0, imem_addr}, 32'h0040);
`ifdef FETCH_PERF_CNT_EN
        chk("squash_cnt", {16'd0, squash_cnt}, 32'd1);
`endif
        tick(12);

        // halt then ignore everything
        do_reset();
        lat_cfg = 1; halt = 1'b1;
        for (int i = 0; i < 40 && !m_halted; i++) tick(1);
        chk("halt_reached", {31'd0, m_halted}, 32'd1);
        halt = 1'b0; spurious = 1'b1;
        for (int i = 0; i < 20; i++) begin
            redirect_valid = ($urandom_range(0, 2) == 0);
            redirect_pc = 16'($urandom);
            tick(1);
        end
        redirect_valid = 1'b0; spurious = 1'b0;
        tick(2);

        // PC wrap and misaligned redirect
        do_reset();
        redirect_to(16'hFFFE);
        tick(10);
        redirect_to(16'h0011);
        tick(4);
        chk("misaligned_err", {31'd0, err}, 32'd1);

        // reset while a request is outstanding
        do_reset();
        lat_cfg = 3;
        wait_req("rst_mid_req");
        tick(1);
        do_reset();
        tick(12);

        // random redirects, stalls and latencies
        do_reset();
        lat_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc = 16'($urandom_range(0, 32767)) << 1;
            tick(1);
        end
        redirect_valid = 1'b0; instr_ready = 1'b0;
        tick(3);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", {16'd0, fetch_cnt}, m_accepts[31:0]);
`endif
        chk("random_progress", {31'd0, (m_accepts > 50)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end: produces the 16-bit instruction stream consumed by the control decoder.
- Holds the PC and issues one-outstanding requests to instruction memory.
- Buffers one returned instruction and presents it downstream with a valid/ready handshake.
- Applies branch/jump redirects and stops on HALT.

Parameters:
- PC_W, 16, PC and memory address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  single-cycle request pulse; imem_addr valid this cycle.
- imem_addr  out  PC_W  word-aligned fetch address.
- imem_rvalid  in  1  response valid; arrives 1 or more cycles after imem_req.
- imem_rdata  in  INSTR_W  returned instruction.
- instr  out  INSTR_W  buffered instruction to decoder.
- instr_pc  out  PC_W  address of instr.
- pc_plus2  out  PC_W  instr_pc+2, used for JAL/JALR link and branch base.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  downstream accepts instr this cycle.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  PC_W  target address.
- halt  in  1  accepted instruction is HALT (decoder pc_en low).
- err  out  1  sticky error: misaligned redirect.

Behaviour:
- Reset (async, any state, including mid-request): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, instr=16'h0800 (NOP), instr_pc=0, instr_valid=0, err=0, squash=0.
- Any response arriving after reset deasserts, for a request issued before reset, is dropped via squash=0 and state IDLE.
- States: IDLE, FETCH, HOLD, HALTED.
- IDLE: next cycle pulse imem_req with imem_addr=pc; go to FETCH.
- FETCH: wait for imem_rvalid.
  - On rvalid with squash=0: instr<=rdata, instr_pc<=pc, pc<=pc+2 (mod 2^16, 16'hFFFE wraps to 16'h0000), instr_valid<=1, go to HOLD.
  - On rvalid with squash=1: drop the data, clear squash, pulse imem_req at pc, stay in FETCH.
- HOLD: instr_valid=1 and instr is held stable until instr_valid&instr_ready. On handshake:
  - halt=1: go to HALTED, instr_valid<=0.
  - Otherwise: instr_valid<=0, pulse imem_req at pc in the same cycle, go to FETCH.
- Throughput: one instruction per 2 cycles with 1-cycle memory.
- Redirect (any state except HALTED) has highest priority:
  - pc<=redirect_pc; instr_valid<=0.
  - In FETCH with no rvalid this cycle: squash<=1.
  - In FETCH with rvalid this cycle: the data is dropped and a new request is issued next cycle.
  - In HOLD: go to IDLE.
- Redirect plus handshake in the same cycle: redirect wins and halt is ignored.
- redirect_pc[0]=1: err<=1, go to HALTED.
- HALTED: imem_req=0, instr_valid=0; leave only via reset. Redirects and responses are ignored.
- At most one request outstanding; imem_req is never asserted while in FETCH awaiting a response.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds outputs fetch_cnt[15:0] and squash_cnt[15:0].
  - fetch_cnt increments per accepted handshake; squash_cnt increments per dropped response.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- fetch_pkg holds: state enum (IDLE, FETCH, HOLD, HALTED), NOP_INSTR=16'h0800, RESET_PC default, PC_INC=2.
- One natural sub-module, fetch_pc_reg: PC register with load (redirect) / increment / hold and wrap.
- FSM, buffer and handshake logic stay in fetch_unit.

Test Plan:
- Reset release, memory latency 1, rdata=16'h4001 at 0, instr_ready=1 → imem_req at addr 0; instr=16'h4001, instr_pc=0, pc_plus2=2; next request at addr 2.
- instr_ready=0 for 5 cycles with instr_valid=1 → instr and instr_pc stable, no imem_req; on ready, request at the next pc.
- Latency 3; redirect_valid to 16'h0040 one cycle after the request → first response dropped, next request at 16'h0040, squash_cnt=1 when enabled.
- Handshake with halt=1 → HALTED; imem_req stays 0 for 20 cycles despite responses and redirects.
- pc=16'hFFFE fetch → next request at 16'h0000; redirect_pc=16'h0011 → err=1, HALTED.
- rst_n low while request outstanding, response arrives during reset → after release, first instr comes from a fresh fetch at RESET_PC; instr_valid=0 through reset.
